// File: rtl/gcm_pkg.sv
// gcm_pkg: shared types for the AES-GCM command sequencer.
// Command codes, FSM states, latency defaults.
package gcm_pkg;

  localparam int GCM_TYPE_W  = 3;
  localparam int GCM_DATA_W  = 128;
  localparam int GCM_IV_W    = 96;
  localparam int GCM_CNT_W   = 8;
  localparam int GCM_BLK_W   = 16;

  localparam int GCM_KEY_LAT = 11;
  localparam int GCM_HJ_LAT  = 14;
  localparam int GCM_BLK_GAP = 1;
  localparam int GCM_TAG_TMO = 64;

  typedef enum logic [2:0] {
    CMD_KEY = 3'd0,
    CMD_IV  = 3'd1,
    CMD_AAD = 3'd2,
    CMD_PLD = 3'd3,
    CMD_EOF = 3'd4
  } gcm_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_AAD_PH   = 2'd1,
    ST_PLD_PH   = 2'd2,
    ST_TAG_WAIT = 2'd3
  } gcm_state_e;

  function automatic logic [GCM_BLK_W-1:0] sat_inc(
    input logic [GCM_BLK_W-1:0] v
  );
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/gcm_seq_ctrl_if.sv
// gcm_seq_ctrl_if: typed command stream into the sequencer.
// master drives commands, slave returns ready.
interface gcm_seq_ctrl_if;
  import gcm_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [GCM_TYPE_W-1:0] cmd_type;
  logic [GCM_DATA_W-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_type,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_type,
    input  cmd_data,
    output cmd_ready
  );

endinterface

// File: rtl/gcm_seq_cnt.sv
// gcm_seq_cnt: loadable down-counter, saturates at zero.
// zero_o marks the hazard window as closed.
module gcm_seq_cnt
  import gcm_pkg::*;
#(
  parameter int W = GCM_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // load wins over the decrement
  always_comb begin
    cnt_d = cnt_q;
    if (ld_i) begin
      cnt_d = ld_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gcm_seq_ctrl.sv
// gcm_seq_ctrl: orders commands into the GCM core and
// spaces the strobes to cover the core's hazards.
module gcm_seq_ctrl
  import gcm_pkg::*;
#(
  parameter int KEY_LAT = GCM_KEY_LAT,
  parameter int HJ_LAT  = GCM_HJ_LAT,
  parameter int BLK_GAP = GCM_BLK_GAP,
  parameter int TAG_TMO = GCM_TAG_TMO
) (
  input  logic                  clk,
  input  logic                  rst,
  gcm_seq_ctrl_if.slave         cmd,
  output logic                  gcm_key_vld_o,
  output logic [GCM_DATA_W-1:0] gcm_key_o,
  output logic                  gcm_iv_vld_o,
  output logic [GCM_IV_W-1:0]   gcm_iv_o,
  output logic                  gcm_aad_vld_o,
  output logic                  gcm_pld_vld_o,
  output logic                  gcm_eof_o,
  output logic [GCM_DATA_W-1:0] gcm_pld_o,
  input  logic                  gcm_tag_vld_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [GCM_BLK_W-1:0]  blk_cnt_o
);

  localparam logic [GCM_CNT_W-1:0] KEY_LD =
    GCM_CNT_W'(KEY_LAT - 1);
  localparam logic [GCM_CNT_W-1:0] HJ_LD =
    GCM_CNT_W'(HJ_LAT - 1);
  localparam logic [GCM_CNT_W-1:0] GAP_LD =
    GCM_CNT_W'(BLK_GAP - 1);
  localparam logic [15:0] TMO_LAST =
    16'(TAG_TMO - 1);

  gcm_state_e state_q, state_d;
  logic       key_ok_q, key_ok_d;
  logic [15:0] tmo_q, tmo_d;

  logic key_vld_q, key_vld_d;
  logic iv_vld_q, iv_vld_d;
  logic aad_vld_q, aad_vld_d;
  logic pld_vld_q, pld_vld_d;
  logic eof_q, eof_d;
  logic done_q, done_d;
  logic err_q, err_d;

  logic [GCM_DATA_W-1:0] key_q, key_d;
  logic [GCM_DATA_W-1:0] pld_q, pld_d;
  logic [GCM_IV_W-1:0]   iv_q, iv_d;
  logic [GCM_BLK_W-1:0]  blk_q, blk_d;

  logic                 key_ld;
  logic                 gap_ld;
  logic [GCM_CNT_W-1:0] gap_val;
  logic                 key_zero;
  logic                 gap_zero;
  logic                 cmd_rdy;
  logic                 cmd_acc;
  logic                 is_key;
  logic                 is_iv;
  logic                 is_aad;
  logic                 is_pld;
  logic                 is_eof;

  gcm_seq_cnt #(.W(GCM_CNT_W)) u_key_cnt (
    .clk      (clk),
    .rst      (rst),
    .ld_i     (key_ld),
    .ld_val_i (KEY_LD),
    .zero_o   (key_zero)
  );

  gcm_seq_cnt #(.W(GCM_CNT_W)) u_gap_cnt (
    .clk      (clk),
    .rst      (rst),
    .ld_i     (gap_ld),
    .ld_val_i (gap_val),
    .zero_o   (gap_zero)
  );

  assign is_key = (cmd.cmd_type == CMD_KEY);
  assign is_iv  = (cmd.cmd_type == CMD_IV);
  assign is_aad = (cmd.cmd_type == CMD_AAD);
  assign is_pld = (cmd.cmd_type == CMD_PLD);
  assign is_eof = (cmd.cmd_type == CMD_EOF);

  // ready depends only on state and hazard counters
  always_comb begin
    cmd_rdy = 1'b0;
    unique case (state_q)
      ST_IDLE:   cmd_rdy = key_zero;
      ST_AAD_PH: cmd_rdy = gap_zero;
      ST_PLD_PH: cmd_rdy = gap_zero;
      default:   cmd_rdy = 1'b0;
    endcase
  end

  assign cmd.cmd_ready = cmd_rdy;
  assign cmd_acc = cmd.cmd_valid & cmd_rdy;

  // next state, strobes and counter loads
  always_comb begin
    state_d   = state_q;
    key_ok_d  = key_ok_q;
    tmo_d     = tmo_q;
    key_vld_d = 1'b0;
    iv_vld_d  = 1'b0;
    aad_vld_d = 1'b0;
    pld_vld_d = 1'b0;
    eof_d     = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    key_d     = key_q;
    iv_d      = iv_q;
    pld_d     = pld_q;
    blk_d     = blk_q;
    key_ld    = 1'b0;
    gap_ld    = 1'b0;
    gap_val   = GAP_LD;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_acc) begin
          unique case (1'b1)
            is_key: begin
              key_vld_d = 1'b1;
              key_d     = cmd.cmd_data;
              key_ok_d  = 1'b1;
              key_ld    = 1'b1;
            end
            is_iv && key_ok_q: begin
              iv_vld_d = 1'b1;
              iv_d     = cmd.cmd_data[GCM_IV_W-1:0];
              gap_ld   = 1'b1;
              gap_val  = HJ_LD;
              blk_d    = '0;
              state_d  = ST_AAD_PH;
            end
            default: err_d = 1'b1;
          endcase
        end
      end

      ST_AAD_PH: begin
        if (cmd_acc) begin
          unique case (1'b1)
            is_aad: begin
              aad_vld_d = 1'b1;
              pld_d     = cmd.cmd_data;
              blk_d     = sat_inc(blk_q);
              gap_ld    = 1'b1;
            end
            is_pld: begin
              pld_vld_d = 1'b1;
              pld_d     = cmd.cmd_data;
              blk_d     = sat_inc(blk_q);
              gap_ld    = 1'b1;
              state_d   = ST_PLD_PH;
            end
            is_eof: begin
              eof_d   = 1'b1;
              gap_ld  = 1'b1;
              tmo_d   = '0;
              state_d = ST_TAG_WAIT;
            end
            default: err_d = 1'b1;
          endcase
        end
      end

      ST_PLD_PH: begin
        if (cmd_acc) begin
          unique case (1'b1)
            is_pld: begin
              pld_vld_d = 1'b1;
              pld_d     = cmd.cmd_data;
              blk_d     = sat_inc(blk_q);
              gap_ld    = 1'b1;
            end
            is_eof: begin
              eof_d   = 1'b1;
              gap_ld  = 1'b1;
              tmo_d   = '0;
              state_d = ST_TAG_WAIT;
            end
            default: err_d = 1'b1;
          endcase
        end
      end

      ST_TAG_WAIT: begin
        if (gcm_tag_vld_i) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // control and strobe registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      key_ok_q  <= 1'b0;
      tmo_q     <= '0;
      key_vld_q <= 1'b0;
      iv_vld_q  <= 1'b0;
      aad_vld_q <= 1'b0;
      pld_vld_q <= 1'b0;
      eof_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      blk_q     <= '0;
    end else begin
      state_q   <= state_d;
      key_ok_q  <= key_ok_d;
      tmo_q     <= tmo_d;
      key_vld_q <= key_vld_d;
      iv_vld_q  <= iv_vld_d;
      aad_vld_q <= aad_vld_d;
      pld_vld_q <= pld_vld_d;
      eof_q     <= eof_d;
      done_q    <= done_d;
      err_q     <= err_d;
      blk_q     <= blk_d;
    end
  end

  // data registers, held between strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q <= '0;
      iv_q  <= '0;
      pld_q <= '0;
    end else begin
      key_q <= key_d;
      iv_q  <= iv_d;
      pld_q <= pld_d;
    end
  end

  assign gcm_key_vld_o = key_vld_q;
  assign gcm_key_o     = key_q;
  assign gcm_iv_vld_o  = iv_vld_q;
  assign gcm_iv_o      = iv_q;
  assign gcm_aad_vld_o = aad_vld_q;
  assign gcm_pld_vld_o = pld_vld_q;
  assign gcm_eof_o     = eof_q;
  assign gcm_pld_o     = pld_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign blk_cnt_o     = blk_q;

endmodule

// File: tb/tb_gcm_seq_ctrl.sv
// tb_gcm_seq_ctrl: two sequencers (BLK_GAP 1 and 3) in
// lockstep with a timestamp-based reference model.
module tb_gcm_seq_ctrl;
  import gcm_pkg::*;

  localparam int KLAT = 11;
  localparam int HLAT = 14;
  localparam int TMO  = 64;

  typedef struct {
    int          ph;
    bit          key_ok;
    int          key_t;
    int          nxt;
    int          eof_t;
    int          blk;
    logic        key_v;
    logic        iv_v;
    logic        aad_v;
    logic        pld_v;
    logic        eof_v;
    logic        done;
    logic        err;
    logic [127:0] key;
    logic [95:0]  iv;
    logic [127:0] pld;
  } mdl_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         v;
  logic [2:0]   t;
  logic [127:0] d;
  logic         tag;

  logic         o_rdy [2];
  logic [7:0]   o_fl  [2];
  logic [127:0] o_key [2];
  logic [95:0]  o_iv  [2];
  logic [127:0] o_pld [2];
  logic [15:0]  o_blk [2];

  mdl_t m [2];
  int   n;
  int   checks;
  int   errors;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    gcm_seq_ctrl_if u_if ();
    logic         kv, ivv, av, pv, ev;
    logic         bz, dn, er;
    logic [127:0] key, pld;
    logic [95:0]  iv;
    logic [15:0]  blk;

    assign u_if.cmd_valid = v;
    assign u_if.cmd_type  = t;
    assign u_if.cmd_data  = d;

    gcm_seq_ctrl #(.BLK_GAP((g == 0) ? 1 : 3)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .cmd           (u_if),
      .gcm_key_vld_o (kv),
      .gcm_key_o     (key),
      .gcm_iv_vld_o  (ivv),
      .gcm_iv_o      (iv),
      .gcm_aad_vld_o (av),
      .gcm_pld_vld_o (pv),
      .gcm_eof_o     (ev),
      .gcm_pld_o     (pld),
      .gcm_tag_vld_i (tag),
      .busy_o        (bz),
      .done_o        (dn),
      .err_o         (er),
      .blk_cnt_o     (blk)
    );

    assign o_rdy[g] = u_if.cmd_ready;
    assign o_fl[g]  = {kv, ivv, av, pv, ev, bz, dn, er};
    assign o_key[g] = key;
    assign o_iv[g]  = iv;
    assign o_pld[g] = pld;
    assign o_blk[g] = blk;
  end

  function automatic int gapv(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic mdl_t mreset();
    mdl_t x;
    x.ph = 0; x.key_ok = 0; x.key_t = -1000;
    x.nxt = 0; x.eof_t = 0; x.blk = 0;
    x.key_v = 0; x.iv_v = 0; x.aad_v = 0;
    x.pld_v = 0; x.eof_v = 0;
    x.done = 0; x.err = 0;
    x.key = '0; x.iv = '0; x.pld = '0;
    return x;
  endfunction

  function automatic bit m_rdy(mdl_t x, int cyc);
    if (x.ph == 0) return cyc >= x.key_t + KLAT;
    if (x.ph == 1 || x.ph == 2) return cyc >= x.nxt;
    return 1'b0;
  endfunction

  function automatic mdl_t step(
    mdl_t x0, int cyc, logic r, logic vv,
    logic [2:0] ty, logic [127:0] dd,
    logic tg, int gap
  );
    mdl_t x;
    bit   acc;
    x = x0;
    x.key_v = 0; x.iv_v = 0; x.aad_v = 0;
    x.pld_v = 0; x.eof_v = 0;
    x.done = 0; x.err = 0;
    if (r) return mreset();
    acc = vv && m_rdy(x0, cyc);
    if (x0.ph == 0) begin
      if (acc) begin
        if (ty == 3'd0) begin
          x.key_v = 1; x.key = dd;
          x.key_ok = 1; x.key_t = cyc;
        end else if (ty == 3'd1 && x0.key_ok) begin
          x.iv_v = 1; x.iv = dd[95:0];
          x.blk = 0; x.nxt = cyc + HLAT; x.ph = 1;
        end else begin
          x.err = 1;
        end
      end
    end else if (x0.ph == 1 || x0.ph == 2) begin
      if (acc) begin
        if (ty == 3'd2 && x0.ph == 1) begin
          x.aad_v = 1; x.pld = dd;
          if (x.blk < 65535) x.blk++;
          x.nxt = cyc + gap;
        end else if (ty == 3'd3) begin
          x.pld_v = 1; x.pld = dd;
          if (x.blk < 65535) x.blk++;
          x.nxt = cyc + gap; x.ph = 2;
        end else if (ty == 3'd4) begin
          x.eof_v = 1; x.nxt = cyc + gap;
          x.ph = 3; x.eof_t = cyc;
        end else begin
          x.err = 1;
        end
      end
    end else begin
      if (tg) begin
        x.done = 1; x.ph = 0;
      end else if (cyc == x0.eof_t + TMO) begin
        x.err = 1; x.ph = 0;
      end
    end
    return x;
  endfunction

  task automatic chk(
    string tg, logic [127:0] got, logic [127:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h exp %0h", tg, got, exp);
    end
  endtask

  task automatic check_dut(int k);
    mdl_t e;
    e = m[k];
    chk($sformatf("d%0d.rdy", k), o_rdy[k], m_rdy(e, n));
    chk($sformatf("d%0d.flags", k), o_fl[k],
        {e.key_v, e.iv_v, e.aad_v, e.pld_v, e.eof_v,
         (e.ph != 0), e.done, e.err});
    chk($sformatf("d%0d.key", k), o_key[k], e.key);
    chk($sformatf("d%0d.iv", k), o_iv[k], e.iv);
    chk($sformatf("d%0d.pld", k), o_pld[k], e.pld);
    chk($sformatf("d%0d.blk", k), o_blk[k], e.blk);
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++)
      m[k] = step(m[k], n, rst, v, t, d, tag, gapv(k));
    n++;
    @(negedge clk);
    for (int k = 0; k < 2; k++) check_dut(k);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send(
    int k, logic [2:0] ty, logic [127:0] dat,
    output int acc
  );
    v = 1'b1; t = ty; d = dat; acc = -1;
    for (int i = 0; i < 300; i++) begin
      if (o_rdy[k]) begin
        acc = n;
        tick();
        break;
      end
      tick();
    end
    v = 1'b0;
    chk("send_accepted", (acc >= 0), 1);
  endtask

  initial begin
    int ka, ia, a, prev, e, errn;
    checks = 0; errors = 0; n = 0;
    rst = 1'b1; v = 1'b0; t = '0; d = '0; tag = 1'b0;
    m[0] = mreset(); m[1] = mreset();
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // ordering errors from idle
    send(0, CMD_IV, rnd128(), a);
    chk("iv_before_key", o_fl[0][0], 1);
    send(0, 3'd7, rnd128(), a);
    chk("illegal_type", o_fl[0][0], 1);

    // key latency and the full message
    send(0, CMD_KEY, rnd128(), ka);
    send(0, CMD_IV, rnd128(), ia);
    chk("key_to_iv", ia + 1 - ka, 12);
    send(0, CMD_AAD, rnd128(), a);
    chk("iv_to_aad", a - ia, 14);
    prev = a;
    send(0, CMD_AAD, rnd128(), a);
    chk("b2b_aad", a - prev, 1);
    prev = a;
    for (int i = 0; i < 3; i++) begin
      send(0, CMD_PLD, rnd128(), a);
      chk("b2b_pld", a - prev, 1);
      prev = a;
    end
    send(0, CMD_EOF, rnd128(), a);
    chk("b2b_eof", a - prev, 1);
    chk("blk_cnt5", o_blk[0], 5);
    repeat (20) tick();
    tag = 1'b1;
    tick();
    tag = 1'b0;
    chk("done_pulse", o_fl[0][1], 1);
    tick();

    // gap of 3 on the second instance
    rst = 1'b1; tick(); rst = 1'b0;
    send(1, CMD_KEY, rnd128(), ka);
    send(1, CMD_IV, rnd128(), ia);
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      send(1, CMD_PLD, rnd128(), a);
      if (i > 0) chk("gap3", a - prev, 3);
      prev = a;
    end
    send(1, CMD_AAD, rnd128(), a);
    chk("aad_after_pld", o_fl[1], 8'b0000_0101);
    send(1, CMD_PLD, rnd128(), a);
    chk("pld_still_ok", o_fl[1][4], 1);

    // tag timeout, then IV reuses the key
    send(1, CMD_EOF, rnd128(), e);
    errn = -1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (o_fl[1][0]) begin
        errn = n;
        break;
      end
    end
    chk("tag_timeout", errn - (e + 1), 64);
    chk("busy_drop", o_fl[1][2], 0);
    send(1, CMD_IV, rnd128(), a);
    chk("iv_no_rekey", o_fl[1][6], 1);

    // reset mid-payload drops the key
    send(1, CMD_PLD, rnd128(), a);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_flags", o_fl[1], 0);
    chk("rst_blk", o_blk[1], 0);
    send(1, CMD_IV, rnd128(), a);
    chk("iv_after_rst", o_fl[1][0], 1);
    send(1, CMD_KEY, rnd128(), ka);
    send(1, CMD_IV, rnd128(), ia);
    chk("iv_after_rekey", o_fl[1][6], 1);

    // random traffic on both instances
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) < 14)
        t = 3'($urandom_range(0, 4));
      else
        t = 3'($urandom_range(5, 7));
      d = rnd128();
      tag = ($urandom_range(0, 39) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
